// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state types for the snake input controller
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_debounce.sv
// rtl/snake_debounce.sv - button synchronizer, debounce counter and press-edge detector
module snake_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;
    logic          differ;
    logic          expire;

    assign differ = (sync2 != level);
    // the level flips on the edge that would complete the Nth disagreeing cycle
    assign expire = differ && (count >= CMAX - 1'b1);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= expire && sync2;
            if (!differ) begin
                count <= '0;
            end else if (expire) begin
                count <= CMAX;
                level <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_input_ctrl.sv
// rtl/snake_input_ctrl.sv - debounced direction buttons feeding the IDLE/RUN direction FSM
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_tick,
    input  logic       i_game_over,
    output logic [1:0] o_dir,
    output logic       o_dir_change,
    output logic       o_start
);

    logic   [3:0] presses;
    logic         any_press;
    dir_t         press_dir;

    state_t       state, state_next;
    dir_t         dir_q, dir_next;
    dir_t         pending_dir, pending_dir_next;
    logic         pending_valid, pending_valid_next;
    logic         start_next, change_next;
    dir_t         ref_dir;
    logic         accept;

    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock(i_clock), .reset(i_reset), .raw(i_up), .press(presses[0])
    );
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock(i_clock), .reset(i_reset), .raw(i_down), .press(presses[1])
    );
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clock(i_clock), .reset(i_reset), .raw(i_left), .press(presses[2])
    );
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clock(i_clock), .reset(i_reset), .raw(i_right), .press(presses[3])
    );

    assign any_press = |presses;
    assign o_dir     = dir_q;

    always_comb begin
        press_dir = RIGHT;
        if (presses[0])      press_dir = UP;
        else if (presses[1]) press_dir = DOWN;
        else if (presses[2]) press_dir = LEFT;
    end

    always_comb begin
        state_next         = state;
        dir_next           = dir_q;
        pending_dir_next   = pending_dir;
        pending_valid_next = pending_valid;
        start_next         = 1'b0;
        change_next        = 1'b0;
        ref_dir            = dir_q;
        accept             = 1'b0;
        unique case (state)
            IDLE: begin
                if (!i_game_over && any_press) begin
                    state_next  = RUN;
                    dir_next    = press_dir;
                    start_next  = 1'b1;
                    change_next = 1'b1;
                end
            end
            RUN: begin
                if (i_game_over) begin
                    state_next         = IDLE;
                    pending_valid_next = 1'b0;
                end else begin
                    if (i_tick && pending_valid) begin
                        dir_next           = pending_dir;
                        change_next        = 1'b1;
                        pending_valid_next = 1'b0;
                        ref_dir            = pending_dir;
                    end
                    // a coincident press is judged against the direction being committed now
                    accept = any_press && (press_dir != ref_dir) && (press_dir != opposite(ref_dir));
                    if (accept) begin
                        pending_dir_next   = press_dir;
                        pending_valid_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            dir_q         <= RIGHT;
            pending_dir   <= RIGHT;
            pending_valid <= 1'b0;
            o_start       <= 1'b0;
            o_dir_change  <= 1'b0;
        end else begin
            state         <= state_next;
            dir_q         <= dir_next;
            pending_dir   <= pending_dir_next;
            pending_valid <= pending_valid_next;
            o_start       <= start_next;
            o_dir_change  <= change_next;
        end
    end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb/tb_snake_input_ctrl.sv - scoreboard bench for snake_input_ctrl with DEBOUNCE_CYCLES=4
module tb_snake_input_ctrl;

    localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
    localparam logic [3:0] B_UP = 4'b0001, B_DOWN = 4'b0010, B_LEFT = 4'b0100, B_RIGHT = 4'b1000;

    typedef struct {
        logic [1:0] dir;
        logic       start;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;
    logic       tick = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] o_dir;
    logic       o_dir_change;
    logic       o_start;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    snake_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_up(btn[0]),
        .i_down(btn[1]),
        .i_left(btn[2]),
        .i_right(btn[3]),
        .i_tick(tick),
        .i_game_over(game_over),
        .o_dir(o_dir),
        .o_dir_change(o_dir_change),
        .o_start(o_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_hold(input logic [3:0] mask, input int hold);
        btn = btn | mask;
        step(hold);
        btn = btn & ~mask;
        step(8);
    endtask

    task automatic do_tick(input bit expect_change, input logic [1:0] d);
        exp_t e;
        if (expect_change) begin
            e.dir = d; e.start = 1'b0; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
    endtask

    task automatic expect_start(input logic [1:0] d);
        exp_t e;
        e.dir = d; e.start = 1'b1; e.cyc = cyc + 7;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (o_dir_change || o_start)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'b0, o_dir_change, o_start}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_dir", o_dir, e.dir);
                check("pulse_start", o_start, e.start);
                check("pulse_change", o_dir_change, 1'b1);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        step(3);
        check("reset_dir", o_dir, D_RIGHT);
        check("reset_start", o_start, 1'b0);
        check("reset_change", o_dir_change, 1'b0);
        rst = 1'b0;
        step(2);

        // first press from IDLE: start pulse 7 cycles after the raw edge
        expect_start(D_UP);
        press_hold(B_UP, 10);

        // short glitch never debounces; tick with nothing pending changes nothing
        press_hold(B_LEFT, 3);
        do_tick(1'b0, D_UP);
        check("glitch_dir", o_dir, D_UP);

        press_hold(B_RIGHT, 8);
        do_tick(1'b1, D_RIGHT);

        // reversal rejected
        press_hold(B_LEFT, 8);
        do_tick(1'b0, D_RIGHT);
        check("reverse_dir", o_dir, D_RIGHT);

        // last accepted press wins
        press_hold(B_UP, 8);
        press_hold(B_DOWN, 8);
        do_tick(1'b1, D_DOWN);
        check("last_wins_dir", o_dir, D_DOWN);

        press_hold(B_RIGHT, 8);
        do_tick(1'b1, D_RIGHT);

        // simultaneous UP and LEFT: UP has priority
        press_hold(B_UP | B_LEFT, 8);
        do_tick(1'b1, D_UP);
        check("priority_dir", o_dir, D_UP);

        // DOWN coinciding with tick is judged against the committed LEFT, not UP
        press_hold(B_LEFT, 8);
        btn[1] = 1'b1;
        step(6);
        do_tick(1'b1, D_LEFT);
        btn[1] = 1'b0;
        step(8);
        do_tick(1'b1, D_DOWN);
        check("coincident_dir", o_dir, D_DOWN);

        // game over in the press-event cycle wins; presses ignored while it stays high
        btn[3] = 1'b1;
        step(6);
        game_over = 1'b1;
        step(4);
        btn[3] = 1'b0;
        step(8);
        check("gameover_dir", o_dir, D_DOWN);
        press_hold(B_UP, 8);
        do_tick(1'b0, D_DOWN);
        check("gameover_hold_dir", o_dir, D_DOWN);
        game_over = 1'b0;
        step(2);
        expect_start(D_LEFT);
        press_hold(B_LEFT, 8);
        check("restart_dir", o_dir, D_LEFT);

        // button held through reset yields one press after release
        btn[0] = 1'b1;
        rst = 1'b1;
        step(3);
        check("reset2_dir", o_dir, D_RIGHT);
        rst = 1'b0;
        expect_start(D_UP);
        step(10);
        btn[0] = 1'b0;
        step(12);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
